// File: rtl/zion_bc_clr_skid_buf.sv
// zion_bc_clr_skid_buf
//  Two-entry valid/ready register slice (skid buffer) with a synchronous clear.
//  Sustains one beat per cycle. oVld, oRdy and oDat all come straight from flops,
//  so no combinational path crosses the slice in either direction.
//  A clear empties the buffer and returns oDat to INI_DATA.
//
// Ports
//  clk   in   1      clock, rising edge
//  rst   in   1      asynchronous reset, active-low
//  iClr  in   1      synchronous flush, active-high
//  iVld  in   1      upstream valid
//  oRdy  out  1      upstream ready (registered)
//  iDat  in   WIDTH  upstream data
//  oVld  out  1      downstream valid (registered)
//  iRdy  in   1      downstream ready
//  oDat  out  WIDTH  downstream data (registered)

module zion_bc_clr_skid_buf #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e           stateQ, stateD;
    logic [WIDTH-1:0] mainQ, mainD;
    logic [WIDTH-1:0] skidQ, skidD;
    logic             oVldQ, oRdyQ;
    logic             push, pop;

    assign push = iVld & oRdyQ;
    assign pop  = oVldQ & iRdy;

    always_comb begin
        stateD = stateQ;
        mainD  = mainQ;
        skidD  = skidQ;
        if (iClr) begin
            // Any beat accepted or delivered this cycle is dropped.
            stateD = StEmpty;
            mainD  = INI_DATA;
            skidD  = INI_DATA;
        end else begin
            unique case (stateQ)
                StEmpty: begin
                    if (push) begin
                        stateD = StOne;
                        mainD  = iDat;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        mainD = iDat;
                    end else if (push) begin
                        stateD = StFull;
                        skidD  = iDat;
                    end else if (pop) begin
                        // oDat keeps the stale beat; only oVld drops.
                        stateD = StEmpty;
                    end
                end
                StFull: begin
                    // oRdy is low here, so no push can occur.
                    if (pop) begin
                        stateD = StOne;
                        mainD  = skidQ;
                    end
                end
                default: stateD = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StEmpty;
            mainQ  <= INI_DATA;
            skidQ  <= INI_DATA;
            oVldQ  <= 1'b0;
            oRdyQ  <= 1'b1;
        end else begin
            stateQ <= stateD;
            mainQ  <= mainD;
            skidQ  <= skidD;
            // Handshake outputs are registered copies of the next-state decode.
            oVldQ  <= (stateD != StEmpty);
            oRdyQ  <= (stateD != StFull);
        end
    end

    assign oVld = oVldQ;
    assign oRdy = oRdyQ;
    assign oDat = mainQ;

    // Handshake inputs must be known whenever the block is out of reset.
    handshakeKnown: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({iVld, iRdy}));

endmodule

// File: tb/tb_zion_bc_clr_skid_buf.sv
module tb_zion_bc_clr_skid_buf;

    localparam logic [31:0] INI = 32'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic        iClr, iVld, iRdy;
    logic [31:0] iDat;
    logic        oRdy, oVld;
    logic [31:0] oDat;

    int checks = 0;
    int failures = 0;

    zion_bc_clr_skid_buf #(
        .WIDTH    (32),
        .INI_DATA (INI)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic        eVld;
        logic        eRdy;
        logic [31:0] eDat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic vld, input logic [31:0] dat,
                         input logic rdy);
        iClr = clr;
        iVld = vld;
        iDat = dat;
        iRdy = rdy;
    endtask

    // Advance one edge and land 1 time unit after it for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic        mVld, mRdy, push, pop;
    logic        rClr, rVld, rRdy;
    logic [31:0] rDat;
    logic        prevStall;
    logic [31:0] prevDat;
    logic [31:0] seqVal;

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #12;
        check("reset_vld", {31'b0, oVld}, 32'd0);
        check("reset_rdy", {31'b0, oRdy}, 32'd1);
        check("reset_dat", oDat, INI);
        rst = 1'b1;
        #4;  // now at t=16, just after the edge at 15

        // Directed table: backpressure, skid fill, drain, clears, stale data.
        vecs[0]  = '{1'b0, 1'b1, 32'hA,    1'b0, 1'b1, 1'b1, 32'hA};
        vecs[1]  = '{1'b0, 1'b1, 32'hB,    1'b0, 1'b1, 1'b0, 32'hA};
        vecs[2]  = '{1'b0, 1'b1, 32'hC,    1'b0, 1'b1, 1'b0, 32'hA};
        vecs[3]  = '{1'b0, 1'b1, 32'hC,    1'b1, 1'b1, 1'b1, 32'hB};
        vecs[4]  = '{1'b0, 1'b1, 32'hC,    1'b1, 1'b1, 1'b1, 32'hC};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'hC};
        vecs[6]  = '{1'b0, 1'b1, 32'hD,    1'b0, 1'b1, 1'b1, 32'hD};
        vecs[7]  = '{1'b0, 1'b1, 32'hE,    1'b0, 1'b1, 1'b0, 32'hD};
        vecs[8]  = '{1'b1, 1'b1, 32'hF,    1'b1, 1'b0, 1'b1, INI};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, INI};
        vecs[10] = '{1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1, INI};
        vecs[11] = '{1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1, 32'hBEEF};
        vecs[12] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'hBEEF};
        vecs[13] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'hBEEF};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].dat, vecs[i].rdy);
            step();
            check($sformatf("vec%0d_vld", i), {31'b0, oVld}, {31'b0, vecs[i].eVld});
            check($sformatf("vec%0d_rdy", i), {31'b0, oRdy}, {31'b0, vecs[i].eRdy});
            check($sformatf("vec%0d_dat", i), oDat, vecs[i].eDat);
        end

        // Streaming: one beat per cycle, no bubbles.
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 1'b1, i, 1'b1);
            step();
            check($sformatf("stream%0d_dat", i), oDat, i);
            check($sformatf("stream%0d_vld", i), {31'b0, oVld}, 32'd1);
            check($sformatf("stream%0d_rdy", i), {31'b0, oRdy}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check("stream_drain_vld", {31'b0, oVld}, 32'd0);

        // Backpressure: A,B,C pushed while stalled, then drained in order.
        drive(1'b0, 1'b1, 32'h100A, 1'b0); step();
        drive(1'b0, 1'b1, 32'h100B, 1'b0); step();
        check("bp_full_rdy", {31'b0, oRdy}, 32'd0);
        drive(1'b0, 1'b1, 32'h100C, 1'b0); step();
        check("bp_hold_dat", oDat, 32'h100A);
        seqVal = 32'h100A;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_drain%0d", i), oDat, seqVal + i);
            check($sformatf("bp_drain%0d_vld", i), {31'b0, oVld}, 32'd1);
            // Keep offering C until it has been accepted.
            if (oRdy && iVld && iDat == 32'h100C) drive(1'b0, 1'b1, 32'h100C, 1'b1);
            else drive(1'b0, iVld, iDat, 1'b1);
            if (i == 2) iVld = 1'b0;
            step();
            if (i == 1 && iVld) iVld = 1'b0;
        end
        check("bp_empty_vld", {31'b0, oVld}, 32'd0);

        // Async reset mid-cycle while holding data.
        drive(1'b0, 1'b1, 32'h55, 1'b0); step();
        check("pre_rst_dat", oDat, 32'h55);
        #2 rst = 1'b0;
        #1;
        check("async_rst_vld", {31'b0, oVld}, 32'd0);
        check("async_rst_rdy", {31'b0, oRdy}, 32'd1);
        check("async_rst_dat", oDat, INI);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Random traffic against a FIFO scoreboard flushed on clear.
        q.delete();
        prevStall = 1'b0;
        prevDat = '0;
        for (int n = 0; n < 400; n++) begin
            mVld = (q.size() > 0);
            mRdy = (q.size() < 2);
            check("rnd_vld", {31'b0, oVld}, {31'b0, mVld});
            check("rnd_rdy", {31'b0, oRdy}, {31'b0, mRdy});
            if (mVld) check("rnd_dat", oDat, q[0]);
            if (prevStall) check("rnd_stall_dat", oDat, prevDat);
            rClr = ($urandom_range(0, 9) == 0);
            rVld = $urandom_range(0, 1) == 1;
            rRdy = $urandom_range(0, 2) != 0;
            rDat = $urandom;
            drive(rClr, rVld, rDat, rRdy);
            push = rVld && mRdy;
            pop = mVld && rRdy;
            prevStall = mVld && !rRdy && !rClr;
            prevDat = oDat;
            step();
            if (rClr) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(rDat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
